// File: rtl/logic_op_pkg.sv
// rtl/logic_op_pkg.sv - shared types for the logic-op issue stage
package logic_op_pkg;

  localparam int DATA_W = 2;

  typedef enum logic [1:0] {
    SEL_AND = 2'b00,
    SEL_OR  = 2'b01,
    SEL_XOR = 2'b10,
    SEL_NOR = 2'b11
  } sel_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    HOLD  = 2'b10
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    sel_e              sel;
  } op_cmd_t;

  // Saturating 8-bit increment for the per-select statistics counters.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/op_cmd_fifo.sv
// rtl/op_cmd_fifo.sv - synchronous command FIFO with wrap-bit pointers
module op_cmd_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic_op_pkg::op_cmd_t      i_wr_data,
  input  logic                       i_pop,
  output logic_op_pkg::op_cmd_t      o_rd_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);
  import logic_op_pkg::*;

  localparam int AW = $clog2(DEPTH);

  op_cmd_t       r_mem [DEPTH];
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic          w_do_push;
  logic          w_do_pop;

  // Same index with differing wrap bits means the write side has lapped the read side.
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_count   = r_wr_ptr - r_rd_ptr;
  assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Storage array; contents need no reset because the pointers qualify them.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
    end
  end

  // Read/write pointers, wrapping naturally through the extra bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/logic_op_issue.sv
// rtl/logic_op_issue.sv - issue stage for the 2-bit logic unit; OP_STATS_EN adds per-select counters
module logic_op_issue #(
  parameter int DATA_W = 2,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [1:0]        in_sel,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic [1:0]        op_s,
  input  logic [DATA_W-1:0] res_and,
  input  logic [DATA_W-1:0] res_or,
  input  logic [DATA_W-1:0] res_xor,
  input  logic [DATA_W-1:0] res_nor,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_res,
`ifdef OP_STATS_EN
  output logic [31:0]       stat_cnt,
`endif
  output logic [1:0]        out_sel
);
  import logic_op_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  state_e            r_state;
  state_e            w_state_next;
  op_cmd_t           w_wr_cmd;
  op_cmd_t           w_rd_cmd;
  logic              w_full;
  logic              w_empty;
  logic [CW-1:0]     w_count;
  logic              w_push;
  logic              w_pop;
  logic              w_load;
  logic              w_capture;
  logic              w_clear;
  logic              w_hs;
  logic [DATA_W-1:0] r_op_a;
  logic [DATA_W-1:0] r_op_b;
  sel_e              r_op_s;
  logic [DATA_W-1:0] r_out_res;
  logic [1:0]        r_out_sel;
  logic              r_out_valid;
  logic [DATA_W-1:0] w_res;

  assign in_ready  = (w_count != CNT_FULL);
  assign w_push    = in_valid && !w_full;
  assign w_hs      = r_out_valid && out_ready;
  assign w_wr_cmd  = '{a: in_a, b: in_b, sel: sel_e'(in_sel)};

  op_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_push    (w_push),
    .i_wr_data (w_wr_cmd),
    .i_pop     (w_pop),
    .o_rd_data (w_rd_cmd),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_count   (w_count)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // Next state and per-cycle control strobes.
  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_load       = 1'b0;
    w_capture    = 1'b0;
    w_clear      = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_load       = 1'b1;
          w_state_next = ISSUE;
        end
      end
      ISSUE: begin
        w_capture    = 1'b1;
        w_state_next = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          w_clear = 1'b1;
          if (!w_empty) begin
            w_pop        = 1'b1;
            w_load       = 1'b1;
            w_state_next = ISSUE;
          end else begin
            w_state_next = IDLE;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Pick the unit output matching the command in flight.
  always_comb begin
    w_res = res_and;
    case (r_op_s)
      SEL_AND: w_res = res_and;
      SEL_OR:  w_res = res_or;
      SEL_XOR: w_res = res_xor;
      SEL_NOR: w_res = res_nor;
      default: w_res = res_and;
    endcase
  end

  // Operand registers only change on a pop, so the unit sees stable inputs while busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op_a <= '0;
      r_op_b <= '0;
      r_op_s <= SEL_AND;
    end else if (w_load) begin
      r_op_a <= w_rd_cmd.a;
      r_op_b <= w_rd_cmd.b;
      r_op_s <= w_rd_cmd.sel;
    end
  end

  // Result capture after the settle cycle; held until the consumer takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_res   <= '0;
      r_out_sel   <= '0;
      r_out_valid <= 1'b0;
    end else if (w_capture) begin
      r_out_res   <= w_res;
      r_out_sel   <= r_op_s;
      r_out_valid <= 1'b1;
    end else if (w_clear) begin
      r_out_valid <= 1'b0;
    end
  end

  assign op_a      = r_op_a;
  assign op_b      = r_op_b;
  assign op_s      = r_op_s;
  assign out_res   = r_out_res;
  assign out_sel   = r_out_sel;
  assign out_valid = r_out_valid;

`ifdef OP_STATS_EN
  logic [7:0] r_stat [4];

  // Count delivered results per select, sticking at 255.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) r_stat[k] <= '0;
    end else if (w_hs) begin
      r_stat[r_out_sel] <= sat_inc8(r_stat[r_out_sel]);
    end
  end

  assign stat_cnt = {r_stat[3], r_stat[2], r_stat[1], r_stat[0]};
`else
  logic w_hs_unused;
  assign w_hs_unused = w_hs;
`endif

endmodule

// File: tb/tb_logic_op_issue.sv
// tb/tb_logic_op_issue.sv - directed bench for logic_op_issue (OP_STATS_EN enables the counter test)
module tb_logic_op_issue;
  import logic_op_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_a, in_b, in_sel;
  logic [1:0] op_a, op_b, op_s;
  logic [1:0] res_and, res_or, res_xor, res_nor;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_res;
  logic [1:0] out_sel;
`ifdef OP_STATS_EN
  logic [31:0] stat_cnt;
`endif

  always #5 clk = ~clk;

  // Behavioural logic unit fed by the issue stage.
  assign res_and = op_a & op_b;
  assign res_or  = op_a | op_b;
  assign res_xor = op_a ^ op_b;
  assign res_nor = ~(op_a | op_b);

  logic_op_issue #(.DATA_W(2), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sel(in_sel),
    .op_a(op_a), .op_b(op_b), .op_s(op_s),
    .res_and(res_and), .res_or(res_or), .res_xor(res_xor), .res_nor(res_nor),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_res(out_res),
`ifdef OP_STATS_EN
    .stat_cnt(stat_cnt),
`endif
    .out_sel(out_sel)
  );

  typedef struct {
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] sel;
    logic [1:0] exp;
  } vec_t;

  vec_t       vec [6];
  logic [3:0] q_exp [$];
  int         n_checks = 0;
  int         n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [1:0] a, input logic [1:0] b, input logic [1:0] s);
    int waited = 0;
    in_valid = 1'b1;
    in_a = a; in_b = b; in_sel = s;
    while (!in_ready && waited < 20) begin
      tick();
      waited++;
    end
    if (!in_ready) chk("push_timeout", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain(input int n, input int budget, input bit chk_spacing);
    int got = 0;
    int cyc = 0;
    int last = -1;
    logic [3:0] e;
    out_ready = 1'b1;
    while (got < n && cyc < budget) begin
      if (out_valid) begin
        e = q_exp.pop_front();
        chk("result", {28'd0, out_sel, out_res}, {28'd0, e});
        if (chk_spacing && last >= 0) chk("spacing", cyc - last, 2);
        last = cyc;
        got++;
      end
      tick();
      cyc++;
    end
    if (got < n) chk("drain_timeout", got, n);
    out_ready = 1'b0;
  endtask

  initial begin
    vec[0] = '{a: 2'b01, b: 2'b11, sel: 2'b00, exp: 2'b01};
    vec[1] = '{a: 2'b01, b: 2'b11, sel: 2'b01, exp: 2'b11};
    vec[2] = '{a: 2'b01, b: 2'b11, sel: 2'b10, exp: 2'b10};
    vec[3] = '{a: 2'b01, b: 2'b11, sel: 2'b11, exp: 2'b00};
    vec[4] = '{a: 2'b10, b: 2'b10, sel: 2'b00, exp: 2'b10};
    vec[5] = '{a: 2'b00, b: 2'b00, sel: 2'b11, exp: 2'b11};

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_sel = '0; out_ready = 1'b0;
    repeat (3) tick();
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_op", {26'd0, op_a, op_b, op_s}, 0);
    chk("rst_out", {28'd0, out_sel, out_res}, 0);
`ifdef OP_STATS_EN
    chk("rst_stat", stat_cnt, 0);
`endif
    rst = 1'b0;
    tick();

    // Single XOR: latency E0 push, E1 issue, E2 result.
    push_one(2'b10, 2'b11, 2'b10);
    chk("lat_e0_valid", 32'(out_valid), 0);
    tick();
    chk("lat_e1_op_s", 32'(op_s), 32'h2);
    chk("lat_e1_op_ab", {28'd0, op_a, op_b}, 32'hb);
    chk("lat_e1_valid", 32'(out_valid), 0);
    tick();
    chk("lat_e2_valid", 32'(out_valid), 1);
    chk("lat_e2_res", 32'(out_res), 32'h1);
    chk("lat_e2_sel", 32'(out_sel), 32'h2);
    tick();
    chk("lat_e2_hold", {29'd0, out_valid, out_res}, 32'h5);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("lat_done_valid", 32'(out_valid), 0);

    // Fill with the consumer stalled; one command sits in HOLD, four in the FIFO.
    for (int i = 0; i < 5; i++) push_one(vec[i].a, vec[i].b, vec[i].sel);
    chk("full_in_ready", 32'(in_ready), 0);
    in_valid = 1'b1; in_a = vec[5].a; in_b = vec[5].b; in_sel = vec[5].sel;
    for (int i = 0; i < 3; i++) begin
      chk("held_in_ready", 32'(in_ready), 0);
      tick();
    end
    for (int i = 0; i < 6; i++) q_exp.push_back({vec[i].sel, vec[i].exp});
    fork
      push_one(vec[5].a, vec[5].b, vec[5].sel);
      drain(6, 200, 1'b0);
    join
    chk("fill_leftover", q_exp.size(), 0);

    // Push while full with a simultaneous pop: push refused, count drops by one.
    for (int i = 0; i < 5; i++) push_one(vec[i].a, vec[i].b, vec[i].sel);
    chk("pwf_count_before", 32'(dut.w_count), 4);
    in_valid = 1'b1; in_a = vec[5].a; in_b = vec[5].b; in_sel = vec[5].sel;
    out_ready = 1'b1;
    chk("pwf_in_ready", 32'(in_ready), 0);
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    chk("pwf_count_after", 32'(dut.w_count), 3);
    chk("pwf_state_issue", 32'(dut.r_state), 32'(ISSUE));

    // Reset while ISSUE is in progress with three commands queued.
    rst = 1'b1;
    tick();
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_in_ready", 32'(in_ready), 1);
    chk("mid_rst_op", {26'd0, op_a, op_b, op_s}, 0);
    rst = 1'b0;
    out_ready = 1'b1;
    begin
      int stale = 0;
      for (int i = 0; i < 10; i++) begin
        if (out_valid) stale++;
        tick();
      end
      chk("no_stale_result", stale, 0);
    end
    out_ready = 1'b0;

    // Streaming with consumer always ready: one result every two cycles.
    for (int i = 0; i < 6; i++) q_exp.push_back({vec[5-i].sel, vec[5-i].exp});
    fork
      for (int i = 0; i < 6; i++) push_one(vec[5-i].a, vec[5-i].b, vec[5-i].sel);
      drain(6, 200, 1'b1);
    join
    chk("stream_leftover", q_exp.size(), 0);

`ifdef OP_STATS_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("stat_clear", stat_cnt, 0);
    for (int i = 0; i < 300; i++) q_exp.push_back({2'b11, 2'b10});
    for (int i = 0; i < 2; i++) q_exp.push_back({2'b00, 2'b01});
    fork
      begin
        for (int i = 0; i < 300; i++) push_one(2'b00, 2'b01, 2'b11);
        for (int i = 0; i < 2; i++) push_one(2'b01, 2'b11, 2'b00);
      end
      drain(302, 3000, 1'b0);
    join
    chk("stat_nor_sat", 32'(stat_cnt[31:24]), 255);
    chk("stat_and", 32'(stat_cnt[7:0]), 2);
    chk("stat_or_xor", 32'(stat_cnt[23:8]), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
